// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO for the execute stage.
// The 64-bit result is computed at issue, held in a pending register, and committed to HI/LO once the busy countdown ends.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [63:0] pending_r;
  logic [63:0] result_s;

  // Result packed as {hi, lo}. Divide corner cases are handled before the
  // native operators so that no divide-by-zero or overflow path is ever used.
  function automatic logic [63:0] md_result(input logic [2:0] op_v,
                                            input logic [31:0] a_v,
                                            input logic [31:0] b_v);
    logic [63:0] res;
    logic [31:0] quo;
    logic [31:0] rem;
    res = 64'd0;
    quo = 32'd0;
    rem = 32'd0;
    case (op_v)
      3'd0: res = {{32{a_v[31]}}, a_v} * {{32{b_v[31]}}, b_v};
      3'd1: res = {32'd0, a_v} * {32'd0, b_v};
      3'd2: begin
        if (b_v == 32'd0) begin
          res = {a_v, 32'hFFFF_FFFF};
        end else if ((a_v == 32'h8000_0000) && (b_v == 32'hFFFF_FFFF)) begin
          res = {32'd0, 32'h8000_0000};
        end else begin
          quo = $signed(a_v) / $signed(b_v);
          rem = $signed(a_v) % $signed(b_v);
          res = {rem, quo};
        end
      end
      3'd3: begin
        if (b_v == 32'd0) begin
          res = {a_v, 32'hFFFF_FFFF};
        end else begin
          quo = a_v / b_v;
          rem = a_v % b_v;
          res = {rem, quo};
        end
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  assign result_s = md_result(op, a, b);
  assign md_stall = busy | (start & ~op[2]);

  // Issue/countdown/commit state machine owning HI, LO and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      pending_r <= 64'd0;
      busy      <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                pending_r <= result_s;
                cnt_r     <= op[1] ? DIV_N : MULT_N;
                busy      <= 1'b1;
                state_r   <= RUN;
              end
              3'd4:    hi <= a;
              3'd5:    lo <= a;
              default: state_r <= IDLE;
            endcase
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          // The counter reaching 1 marks the N-th edge after issue.
          if (cnt_r == 4'd1) begin
            hi      <= pending_r[63:32];
            lo      <= pending_r[31:0];
            busy    <= 1'b0;
            cnt_r   <= 4'd0;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: the driver pushes model results with their due cycle,
// and a monitor applies them and checks HI/LO/busy/md_stall every cycle.
module tb_md_unit;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    bit          wr_hi;
    bit          wr_lo;
    logic [31:0] hv;
    logic [31:0] lv;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;
  int          busy_start = 0;
  int          busy_end = 0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic bit busy_at(input int c);
    return (c >= busy_start) && (c < busy_end);
  endfunction

  // Reference arithmetic on 64-bit integers; returns {hi, lo}.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] ux, uy, uq, ur, qv, rv;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      3'd0: return sx * sy;
      3'd1: return ux * uy;
      3'd2: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sx / sy;
        r = sx - q * sy;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
      end
      3'd3: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Called at a falling edge; drives one start pulse and records what the unit must do.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] r;
    int n;
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    if (!busy_at(cyc)) begin
      if (o <= 3'd3) begin
        r = ref_result(o, x, y);
        n = (o >= 3'd2) ? DIV_N : MULT_N;
        sb.push_back('{cyc + 1 + n, 1'b1, 1'b1, r[63:32], r[31:0]});
        busy_start = cyc + 1;
        busy_end = cyc + 1 + n;
      end else if (o == 3'd4) begin
        sb.push_back('{cyc + 1, 1'b1, 1'b0, x, 32'd0});
      end else if (o == 3'd5) begin
        sb.push_back('{cyc + 1, 1'b0, 1'b1, 32'd0, x});
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (cyc < busy_end && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) begin
      bad++;
      total++;
      $display("FAIL wait_idle: timeout, cycle %0d busy_end %0d", cyc, busy_end);
    end
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    busy_start = 0;
    busy_end = 0;
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: retire due scoreboard entries, then compare every visible output.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          if (e.wr_hi) exp_hi = e.hv;
          if (e.wr_lo) exp_lo = e.lv;
        end
        chk("hi", hi, exp_hi);
        chk("lo", lo, exp_lo);
        chk("busy", {31'd0, busy}, {31'd0, busy_at(cyc)});
        chk("md_stall", {31'd0, md_stall}, {31'd0, busy_at(cyc) | (start & (op <= 3'd3))});
      end
    end
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    #1 rst_n = 1'b0;
    #2;
    chk("init_hi", hi, 32'd0);
    chk("init_lo", lo, 32'd0);
    chk("init_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_idle();
    chk("multu_hi", hi, 32'd1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);
    issue(3'd0, -32'sd3, 32'd5);
    wait_idle();
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);
    issue(3'd2, -32'sd7, 32'd2);
    wait_idle();
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    chk("divov_hi", hi, 32'd0);
    chk("divov_lo", lo, 32'h8000_0000);
    issue(3'd3, 32'h1234, 32'd0);
    wait_idle();
    chk("divz_hi", hi, 32'h1234);
    chk("divz_lo", lo, 32'hFFFF_FFFF);

    issue(3'd2, 32'd100, 32'd7);
    idle(2);
    issue(3'd4, 32'hDEAD, 32'd0);
    wait_idle();
    chk("collide_hi", hi, 32'd2);
    chk("collide_lo", lo, 32'd14);
    issue(3'd5, 32'd7, 32'd0);
    chk("mtlo_lo", lo, 32'd7);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    issue(3'd6, 32'h5555, 32'h1);
    idle(1);

    issue(3'd0, 32'd6, 32'd7);
    idle(1);
    reset_mid();
    issue(3'd0, 32'd6, 32'd7);
    wait_idle();
    chk("reissue_hi", hi, 32'd0);
    chk("reissue_lo", lo, 32'd42);

    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      issue(ro, ra, rb);
      if ($urandom_range(0, 3) == 0) wait_idle();
      else idle($urandom_range(0, 3));
    end

    wait_idle();
    idle(2);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the execute stage of the 5-stage MIPS pipeline, directly downstream of the D/E pipeline register.
- Takes the forwarded RS/RT operands and a decoded operation from execute-stage control.
- Runs MULT/MULTU/DIV/DIVU over a fixed number of cycles and holds the architectural HI/LO registers.
- Exposes busy/stall so the hazard unit can freeze decode while any later HI/LO access is pending.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  issue strobe; execute stage holds a valid md op this cycle
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, 6-7 reserved
- a  in  32  RS operand (forwarded)
- b  in  32  RT operand (forwarded)
- busy  out  1  registered; operation in flight
- md_stall  out  1  combinational = busy | (start & op<=3); fed to hazard unit
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (async, rst_n=0): hi=0, lo=0, busy=0, cycle counter=0, pending result cleared. This takes effect immediately, not at the next edge.
- Reset mid-operation: the operation is abandoned and HI/LO read 0 afterwards.
- States: IDLE, RUN. Counter width 4 bits.
- IDLE with start=1 and op in 0..3 at edge T:
  - Compute the 64-bit result from a,b.
  - Latch it into an internal pending register; HI/LO are not yet updated.
  - Load the counter with MULT_CYCLES or DIV_CYCLES (N); busy<=1; go to RUN.
- RUN, each edge: counter decrements.
- At edge T+N: hi/lo <= pending result, busy<=0, return to IDLE.
  - busy is high for exactly N cycles after the issuing edge.
  - A new op may issue in the cycle busy falls, i.e. issue edge T+N+1 at the earliest.
- Result encoding:
  - MULT: signed 32x32, {hi,lo} = a*b as 64-bit two's complement.
  - MULTU: unsigned 64-bit product.
  - DIV: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
- Divide by zero (b=0), DIV and DIVU: lo=32'hFFFF_FFFF, hi=a. Normal busy timing applies.
- DIV overflow (a=32'h8000_0000, b=32'hFFFF_FFFF): lo=32'h8000_0000, hi=0.
- MTHI/MTLO in IDLE with start=1: hi<=a (or lo<=a) at the same edge; busy stays 0; no RUN.
- start while busy=1 (any op): ignored. No latch, no HI/LO write. The hazard unit must prevent this; the behaviour is defined for robustness.
- Reserved op with start=1: no effect.
- start=0: no state change other than the RUN countdown.
- hi/lo are readable every cycle. During RUN they show the previous values; MFHI/MFLO must be stalled by the hazard unit via md_stall.

Test Plan:
- Reset: assert rst_n=0 asynchronously, mid-cycle -> hi=0, lo=0, busy=0 before the next clk edge.
- MULTU a=32'hFFFF_FFFF, b=2, start one cycle:
  - busy=1 for 5 cycles; hi/lo unchanged until the falling edge of busy.
  - Then hi=1, lo=32'hFFFF_FFFE. md_stall=1 in the issue cycle.
- MULT a=-3, b=5 -> after 5 cycles hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1.
- DIV a=-7, b=2 -> after 10 cycles lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
- DIV overflow: DIV a=32'h8000_0000, b=-1 -> lo=32'h8000_0000, hi=0.
- DIVU a=32'h1234, b=0 -> lo=32'hFFFF_FFFF, hi=32'h1234, after 10 cycles.
- Collision and moves:
  - Issue DIV, then pulse MTHI a=32'hDEAD during busy -> MTHI ignored, DIV result lands normally.
  - Then MTLO a=7 in IDLE -> lo=7 at the next edge, busy stays 0.
- Reset mid-RUN: issue MULT 6*7, drop rst_n at cycle 3 -> hi=lo=0, busy=0.
  - A re-issue after reset completes with lo=42, hi=0.
